serial_frame_rx: RTL and testbench

- Downstream consumer of the 4-stage serial shift-register chain.
- Takes the 1-bit serial stream at the chain output and finds framed words: start bit, DATA_W data bits LSB-first, optional parity bit, stop bit.
- Presents each word in parallel with a valid/ready handshake, plus parity, frame and overrun status.
- Line rate is one bit per in_clk cycle; there is no oversampling.

---
 rtl/serial_pkg.sv | 17 +
 rtl/sipo_en.sv | 29 ++
 rtl/serial_frame_rx.sv | 102 ++++++++++
 tb/tb_serial_frame_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding and parity helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Expected parity bit for a word (zero-extended to 32 bits; extra zeros do not affect XOR).
    // Even parity: data ^ parity == 0, so the expected bit is ^data; odd inverts it.
    function automatic logic parity_bit(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sipo_en.sv
// Serial-in/parallel-out register, LSB-first: new bits enter at the MSB and shift right,
// so after W enabled shifts bit 0 holds the first bit received.
module sipo_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sd,
    output logic [W-1:0] q
);

    generate
        if (W == 1) begin : g_one
            // Single-bit register just captures the line when enabled
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (en) q <= sd;
            end
        end else begin : g_multi
            // Shift right, inserting the new bit at the MSB
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (en) q <= {sd, q[W-1:1]};
            end
        end
    endgenerate

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional parity, stop bit.
// Delivers words through a single-entry valid/ready slot with parity, frame and overrun status.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_sd,
    input  logic              in_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_perr,
    output logic              o_frm_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int              CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic               perr_q;
    logic [DATA_W-1:0]  shreg;
    logic               shift_en;

    assign shift_en = (state == DATA);

    sipo_en #(.W(DATA_W)) u_sipo (
        .clk (in_clk),
        .rst (in_rst),
        .en  (shift_en),
        .sd  (in_sd),
        .q   (shreg)
    );

    // Frame FSM, bit counter, arming and the output slot with its status pulses.
    // The line idles high, but the upstream chain resets to 0, so a start bit is
    // only trusted after the line has been seen high at least once (armed).
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            perr_q    <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_perr    <= 1'b0;
            o_frm_err <= 1'b0;
            o_overrun <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_frm_err <= 1'b0;
            o_overrun <= 1'b0;
            if (o_valid && in_ready) o_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_sd) armed <= 1'b1;
                    if (armed && !in_sd) begin
                        state  <= DATA;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    // Full word is in the shift register once we get here
                    perr_q <= in_sd ^ parity_bit(32'(shreg), PARITY_ODD);
                    state  <= STOP;
                end
                STOP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    if (in_sd) begin
                        // Slot is free, or being emptied this same cycle: take the new word
                        if (!o_valid || in_ready) begin
                            o_valid <= 1'b1;
                            o_data  <= shreg;
                            o_perr  <= PARITY_EN & perr_q;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                    end else begin
                        o_frm_err <= 1'b1;
                        armed     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx (DATA_W=8, even parity) with a frame-level reference
// model feeding scoreboard queues, plus directed async-reset and re-arming checks.
module tb_serial_frame_rx;

    logic       in_clk = 1'b0;
    logic       in_rst, in_sd, in_ready;
    logic [7:0] o_data;
    logic       o_valid, o_perr, o_frm_err, o_overrun, o_busy;

    always #5 in_clk = ~in_clk;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_sd     (in_sd),
        .in_ready  (in_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_perr    (o_perr),
        .o_frm_err (o_frm_err),
        .o_overrun (o_overrun),
        .o_busy    (o_busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         c;
    } acc_t;

    acc_t acc_q[$];
    int   frm_q[$];
    int   ovr_q[$];
    bit   line[$];
    bit   rdy[$];
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    acc_t mon_e;
    int   mon_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    // Frame bits onto the line: start, data LSB-first, parity (optionally wrong), stop (optionally 0)
    task automatic add_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        line.push_back(1'b0);
        for (int k = 0; k < 8; k++) line.push_back(d[k]);
        line.push_back((^d) ^ bad_par);
        line.push_back(!bad_stop);
    endtask

    // Reference: parse the line as frames, then replay the single output slot against in_ready
    task automatic build_model();
        int         n;
        int         i;
        bit         armed;
        bit         good_at[];
        logic [7:0] word_at[];
        bit         perr_at[];
        logic [7:0] d;
        bit         v;
        logic [7:0] w;
        bit         wp;
        bit         hs;
        n = line.size();
        good_at = new[n + 2];
        word_at = new[n + 2];
        perr_at = new[n + 2];
        armed = 1'b0;
        i = 0;
        while (i < n) begin
            if (!armed) begin
                if (line[i]) armed = 1'b1;
                i++;
            end else if (line[i]) begin
                i++;
            end else if (i + 10 < n) begin
                for (int k = 0; k < 8; k++) d[k] = line[i + 1 + k];
                if (line[i + 10]) begin
                    good_at[i + 11] = 1'b1;
                    word_at[i + 11] = d;
                    perr_at[i + 11] = ^{d, line[i + 9]};
                end else begin
                    frm_q.push_back(i + 11);
                    armed = 1'b0;
                end
                i += 11;
            end else begin
                i = n;
            end
        end
        v = 1'b0; w = '0; wp = 1'b0;
        for (int m = 0; m < n; m++) begin
            hs = v && rdy[m];
            if (hs) acc_q.push_back('{d: w, p: wp, c: m});
            if (good_at[m + 1]) begin
                if (!v || rdy[m]) begin
                    v = 1'b1; w = word_at[m + 1]; wp = perr_at[m + 1];
                end else begin
                    ovr_q.push_back(m + 1);
                end
            end else if (hs) begin
                v = 1'b0;
            end
        end
    endtask

    task automatic send_bit(input bit b);
        in_sd = b;
        @(posedge in_clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or a status pulse
    always @(negedge in_clk) begin
        if (mon_en) begin
            if (o_valid && in_ready) begin
                if (acc_q.size() == 0) chk("unexpected_word", {24'd0, o_data}, 32'hFFFF_FFFF);
                else begin
                    mon_e = acc_q.pop_front();
                    chk("word_data", {24'd0, o_data}, {24'd0, mon_e.d});
                    chk("word_perr", o_perr, mon_e.p);
                    chk("word_cycle", cyc, mon_e.c);
                end
            end
            if (o_frm_err) begin
                if (frm_q.size() == 0) chk("unexpected_frm_err", 1, 0);
                else begin mon_c = frm_q.pop_front(); chk("frm_err_cycle", cyc, mon_c); end
            end
            if (o_overrun) begin
                if (ovr_q.size() == 0) chk("unexpected_overrun", 1, 0);
                else begin mon_c = ovr_q.pop_front(); chk("overrun_cycle", cyc, mon_c); end
            end
            if (cyc < 20) begin
                chk("busy_unarmed", o_busy, 0);
                chk("valid_unarmed", o_valid, 0);
            end
        end
    end

    initial begin
        bit v;
        int len;
        logic [7:0] d;
        in_rst = 1'b1; in_sd = 1'b0; in_ready = 1'b0;

        // Line held low after reset (must not start), one high bit arms, then directed + random frames
        repeat (20) line.push_back(1'b0);
        line.push_back(1'b1);
        add_frame(8'h5A, 0, 0); line.push_back(1'b1);
        add_frame(8'hA5, 0, 0);
        add_frame(8'h3C, 1, 0);
        add_frame(8'h0F, 0, 1);
        add_frame(8'h33, 0, 0);          // start right after a frame error: not accepted
        repeat (3) line.push_back(1'b1);
        add_frame(8'h11, 0, 0);
        add_frame(8'h22, 0, 0);          // back-to-back
        for (int f = 0; f < 150; f++) begin
            repeat ($urandom_range(0, 3)) line.push_back(1'b1);
            add_frame(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end
        repeat (30) line.push_back(1'b1);
        while (rdy.size() < line.size()) begin
            v = $urandom_range(0, 9) < 6;
            len = $urandom_range(1, 12);
            repeat (len) rdy.push_back(v);
        end
        while (rdy.size() > line.size()) void'(rdy.pop_back());
        for (int k = 0; k < 8; k++) rdy[50 + k] = 1'b0;   // hold the slot full over some completions
        for (int k = rdy.size() - 30; k < rdy.size(); k++) rdy[k] = 1'b1;
        build_model();

        #12;
        chk("rst_data", {24'd0, o_data}, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_perr", o_perr, 0);
        chk("rst_frm_err", o_frm_err, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_busy", o_busy, 0);
        @(negedge in_clk);
        in_rst = 1'b0;
        @(posedge in_clk);
        #1;
        mon_en = 1'b1;
        for (int m = 0; m < line.size(); m++) begin
            cyc = m;
            in_sd = line[m];
            in_ready = rdy[m];
            @(posedge in_clk);
            #1;
        end
        mon_en = 1'b0;
        chk("words_left", acc_q.size(), 0);
        chk("frm_errs_left", frm_q.size(), 0);
        chk("overruns_left", ovr_q.size(), 0);

        // Async reset mid-frame while a word is held
        in_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1);
        d = 8'h77;
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
        send_bit(^d); send_bit(1'b1);
        chk("p2_valid_held", o_valid, 1);
        d = 8'h5A;
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(d[k]);
        chk("p2_busy_mid", o_busy, 1);
        in_sd = d[4];
        #2 in_rst = 1'b1;
        #1;
        chk("p2_async_busy", o_busy, 0);
        chk("p2_async_valid", o_valid, 0);
        chk("p2_async_data", {24'd0, o_data}, 0);
        @(posedge in_clk);
        #1 in_rst = 1'b0;
        in_ready = 1'b1;
        for (int k = 4; k < 8; k++) begin send_bit(d[k]); chk("p2_tail_valid", o_valid, 0); end
        send_bit(^d); chk("p2_tail_valid", o_valid, 0);
        send_bit(1'b1); chk("p2_tail_valid", o_valid, 0);
        repeat (12) begin send_bit(1'b0); chk("p2_low_valid", o_valid, 0); end
        send_bit(1'b1);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
        send_bit(^d);
        chk("p2_pre_valid", o_valid, 0);
        in_ready = 1'b0;
        send_bit(1'b1);
        chk("p2_fresh_valid", o_valid, 1);
        chk("p2_fresh_data", {24'd0, o_data}, 32'h5A);
        chk("p2_fresh_perr", o_perr, 0);
        in_ready = 1'b1;
        send_bit(1'b1);
        chk("p2_consumed", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
